delta_sigma_decoder: RTL and testbench
======================================

// Module: delta_sigma_decoder
// PURPOSE
//  Receive end of the 1-bit DeltaSigma DAC stream: a third-order CIC (sinc3) decimator.
//  It turns pinX/pinY-style bitstreams back into sampleBits-wide unsigned samples.
//  Used for on-board loopback checks of the scope outputs and as a generic 1-bit ADC front end.
//  One instance per bitstream; runs in the modulator's clock domain (clk).
// PARAMETERS
//  decimationLog2  6   log2 of decimation ratio R (R = 64); legal range 2..10
//  sampleBits      16  output sample width; matches deltaSigmaBits; must be <= 3*decimationLog2
// PORTS
//  clk          input   1           clock, same clock as the DeltaSigma modulator
//  reset        input   1           asynchronous, active-high; clears all state
//  bitIn        input   1           modulator bitstream; 1 = +1, 0 = 0 (unipolar)
//  sample       output  sampleBits  decoded unsigned sample, offset binary as fed to DeltaSigma
//  sampleValid  output  1           one-cycle strobe; sample is new on this cycle
//  clipped      output  1           sticky; set when a sample saturated; cleared only by reset
// BEHAVIOUR
//  - Internal width W = 3*decimationLog2+1; integrators and combs wrap modulo 2^W (intentional, CIC-correct).
//  - Reset: integrators, comb delays, pipeline, decimation counter and warm-up counter = 0; sample = 0;
//    sampleValid = 0; clipped = 0. Asserting reset mid-frame discards the partial frame; no strobe follows.
//  - Integrators: every clk, i1 += bitIn; i2 += i1; i3 += i2 (each uses the registered value of the previous stage).
//  - Decimation counter: 0..R-1, increments every clk, wraps to 0.
//    Tick = counter == R-1; on a tick edge c0 <= i3, pre-update value.
//  - Comb pipeline, one stage per clk after the tick:
//      T+1: c1 <= c0 - d0; d0 <= c0.   T+2: c2 <= c1 - d1; d1 <= c1.   T+3: c3 <= c2 - d2; d2 <= c2.
//  - T+4: scale and register the output, sample <= c3 >> (3*decimationLog2 - sampleBits).
//    If the shifted value exceeds 2^sampleBits-1, sample <= all ones and clipped <= 1.
//    Only all-ones input reaching R^3 can do this.
//  - sampleValid pulses high on the T+4 cycle only, i.e. 4 clks after each tick. Output rate = clk / R.
//    R >= 4 guarantees the pipeline drains before the next tick; there are no overlapping frames.
//  - Warm-up: the first 3 computed samples after reset have sampleValid suppressed (filter fill).
//    sample still updates on those cycles. The first strobe is on the 4th tick + 4 clks.
//    The warm-up counter saturates at 3.
//  - Steady state: input density p maps to sample = p * 2^sampleBits (floor), saturating at all ones.
//  - Between strobes, sample holds its value.
// CONFIGURATION
//  - SYNC_INPUT_EN defined: bitIn passes through a 2-flop synchronizer, reset to 0, before the integrators.
//    This adds 2 clks latency from bitIn to the integrators; tick-to-strobe timing is unchanged.
//    Use it when bitIn comes from a pin or another domain.
//  - SYNC_INPUT_EN undefined: bitIn feeds i1 directly (same-domain loopback); no extra latency.
// TESTING
//  1 Constant bitIn=0 for 10*R clks -> every strobe sample=0x0000, clipped=0.
//  2 Constant bitIn=1 after warm-up -> sample=0xFFFF on every strobe, clipped=1 from the first clipped sample.
//  3 Alternating 1010... -> after warm-up every sample=0x8000; strobes exactly R=64 clks apart.
//  4 Reset -> count strobes: the first strobe is at clk 4*R+3 after reset release (counter phase 0).
//    sampleValid stays 0 before that.
//  5 Loopback: DeltaSigma #(16) driven with 0x4000 -> bitIn -> samples within 0x4000 +/- 0x0100 after warm-up.
//    Repeat with 0xC000.
//  6 Reset asserted mid-frame (counter=30) with bitIn=1 -> all outputs 0 immediately, asynchronous.
//    After release the warm-up restarts (3 suppressed samples).
//  7 Run 1..6 with SYNC_INPUT_EN both defined and undefined.
//    Defined: same values, bitIn effect delayed by 2 clks.

Source files
------------

// File: rtl/delta_sigma_decoder.sv
// -----------------------------------------------------------------------------
// delta_sigma_decoder
//   Third-order CIC (sinc3) decimator that turns a 1-bit unipolar DeltaSigma
//   bitstream back into unsigned offset-binary samples. Decimation ratio is
//   R = 2**decimationLog2. One output sample per R clocks.
//
// Ports
//   clk          clock, shared with the DeltaSigma modulator
//   reset        asynchronous, active-high; clears all state
//   bitIn        modulator bitstream (1 = +1, 0 = 0)
//   sample       decoded unsigned sample, holds between strobes
//   sampleValid  one-cycle strobe marking a new sample (suppressed during warm-up)
//   clipped      sticky saturation flag, cleared only by reset
//
// Build option
//   SYNC_INPUT_EN  when defined, bitIn passes through a 2-flop synchronizer
//                  before the integrators (2 clks extra input latency).
// -----------------------------------------------------------------------------
module delta_sigma_decoder #(
  parameter int decimationLog2 = 6,
  parameter int sampleBits     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bitIn,
  output logic [sampleBits-1:0] sample,
  output logic                  sampleValid,
  output logic                  clipped
);

  // Internal width holds R^3 exactly; wrap-around in integrators and combs
  // cancels out in the comb differences.
  localparam int W     = 3 * decimationLog2 + 1;
  localparam int SHIFT = 3 * decimationLog2 - sampleBits;
  localparam logic [decimationLog2-1:0] CNT_ONE = 1;

  logic bit_int;

`ifdef SYNC_INPUT_EN
  logic sync_a;
  logic sync_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= bitIn;
      sync_b <= sync_a;
    end
  end

  assign bit_int = sync_b;
`else
  assign bit_int = bitIn;
`endif

  // Integrators: each stage adds the registered value of the previous one.
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + {{(W-1){1'b0}}, bit_int};
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Decimation counter; the tick is the last cycle of each frame.
  logic [decimationLog2-1:0] counter;
  logic                      tick;

  assign tick = (counter == {decimationLog2{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else begin
      counter <= counter + CNT_ONE;
    end
  end

  // Frame pipeline: stage[n] is high on the cycle after comb stage n was loaded.
  logic [3:0]   stage;
  logic [W-1:0] c0;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [W-1:0] c3;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
      c0    <= '0;
      c1    <= '0;
      c2    <= '0;
      c3    <= '0;
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
    end else begin
      stage <= {stage[2:0], tick};
      if (tick) begin
        c0 <= i3;
      end
      if (stage[0]) begin
        c1 <= c0 - d0;
        d0 <= c0;
      end
      if (stage[1]) begin
        c2 <= c1 - d1;
        d1 <= c1;
      end
      if (stage[2]) begin
        c3 <= c2 - d2;
        d2 <= c2;
      end
    end
  end

  // Output scaling. Only a full-scale (all ones) window reaches R^3, which
  // shifts to exactly 2^sampleBits and must be saturated.
  logic [W-1:0]          scaled;
  logic                  overflow;
  logic [sampleBits-1:0] sample_next;

  assign scaled      = c3 >> SHIFT;
  assign overflow    = |scaled[W-1:sampleBits];
  assign sample_next = overflow ? {sampleBits{1'b1}} : scaled[sampleBits-1:0];

  // Warm-up: the first three samples come from a partially filled filter.
  logic [1:0] warm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample      <= '0;
      sampleValid <= 1'b0;
      clipped     <= 1'b0;
      warm        <= 2'd0;
    end else begin
      sampleValid <= 1'b0;
      if (stage[3]) begin
        sample      <= sample_next;
        sampleValid <= (warm == 2'd3);
        if (warm != 2'd3) begin
          warm <= warm + 2'd1;
        end
        if (overflow) begin
          clipped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_delta_sigma_decoder.sv
module tb_delta_sigma_decoder;

  localparam int R     = 64;
  localparam int SHIFT = 2;      // 3*log2(R) - 16
  localparam int KLEN  = 3 * R - 2;
  localparam int MAXE  = 2048;
`ifdef SYNC_INPUT_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        clipped;

  int checks = 0;
  int errors = 0;

  int b3 [0:KLEN-1];
  int x_hist [0:MAXE-1];
  logic [15:0] exp_sample;
  logic        exp_clip;

  always #5 clk = ~clk;

  delta_sigma_decoder #(.decimationLog2(6), .sampleBits(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bitIn       (bit_in),
    .sample      (sample),
    .sampleValid (sample_valid),
    .clipped     (clipped)
  );

  // sinc3 impulse response: three length-R boxcars convolved together.
  task automatic build_kernel();
    int b2 [0:2*R-2];
    for (int k = 0; k < 2 * R - 1; k++) begin
      b2[k] = 0;
      for (int a = 0; a < R; a++)
        if (k - a >= 0 && k - a < R) b2[k] += 1;
    end
    for (int k = 0; k < KLEN; k++) begin
      b3[k] = 0;
      for (int a = 0; a < R; a++)
        if (k - a >= 0 && k - a < 2 * R - 1) b3[k] += b2[k - a];
    end
  endtask

  // Filter output for frame j: window ending 4 clks before the j-th tick edge,
  // plus the optional synchronizer delay. History before reset is zero.
  function automatic longint frame_sum(input int j);
    longint y = 0;
    for (int k = 0; k < KLEN; k++) begin
      int idx = j * R - 4 - k - D;
      if (idx >= 0) y += longint'(b3[k]) * longint'(x_hist[idx]);
    end
    return y;
  endfunction

  // Called at a negedge; asserts reset between edges and checks the outputs
  // clear without waiting for a clock edge.
  task automatic apply_reset(input string name);
    #2;
    reset  = 1'b1;
    bit_in = 1'b0;
    #1;
    checks++;
    if (sample !== 16'h0000 || sample_valid !== 1'b0 || clipped !== 1'b0) begin
      errors++;
      $display("FAIL %s_async_reset: sample=%h valid=%b clipped=%b expected 0000/0/0",
               name, sample, sample_valid, clipped);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    exp_sample = 16'h0000;
    exp_clip   = 1'b0;
  endtask

  // mode: 0 zeros, 1 ones, 2 alternating 1010, 3 random with density thr/65536.
  // exp_const >= 0 additionally pins every valid strobe to that value.
  task automatic run_frames(input string name, input int nframes, input int mode,
                            input int thr, input int exp_const, input int stop_at,
                            output int strobes);
    strobes = 0;
    for (int e = 0; e < nframes * R + 4; e++) begin
      logic b;
      logic exp_valid;
      logic strobe_edge;
      if (stop_at >= 0 && e == stop_at) return;
      case (mode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (e % 2 == 0);
        default: b = ($urandom_range(0, 65535) < thr);
      endcase
      x_hist[e] = int'(b);
      bit_in = b;
      @(posedge clk);
      @(negedge clk);
      strobe_edge = (e >= R + 3) && ((e - 3) % R == 0);
      exp_valid   = strobe_edge && ((e - 3) / R >= 4);
      if (strobe_edge) begin
        longint s = frame_sum((e - 3) / R) >>> SHIFT;
        if (s > 65535) begin
          exp_sample = 16'hFFFF;
          exp_clip   = 1'b1;
        end else begin
          exp_sample = 16'(s);
        end
      end
      if (sample_valid === 1'b1) strobes++;
      checks++;
      if (sample_valid !== exp_valid) begin
        errors++;
        if (errors < 40)
          $display("FAIL %s_valid: edge %0d valid=%b expected %b", name, e, sample_valid, exp_valid);
      end
      checks++;
      if (sample !== exp_sample) begin
        errors++;
        if (errors < 40)
          $display("FAIL %s_sample: edge %0d sample=%h expected %h", name, e, sample, exp_sample);
      end
      checks++;
      if (clipped !== exp_clip) begin
        errors++;
        if (errors < 40)
          $display("FAIL %s_clipped: edge %0d clipped=%b expected %b", name, e, clipped, exp_clip);
      end
      if (exp_valid && exp_const >= 0) begin
        checks++;
        if (sample !== 16'(exp_const)) begin
          errors++;
          $display("FAIL %s_const: edge %0d sample=%h expected %h", name, e, sample, 16'(exp_const));
        end
      end
      if (exp_valid)
        $display("%s: strobe edge %0d sample=%h clipped=%b", name, e, sample, clipped);
    end
  endtask

  task automatic check_strobes(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_strobe_count: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (sample !== 16'h0000 || sample_valid !== 1'b0 || clipped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sample=%h valid=%b clipped=%b expected 0000/0/0",
               sample, sample_valid, clipped);
    end
    $display("reset: sample=%h valid=%b clipped=%b", sample, sample_valid, clipped);
  endtask

  task automatic test_zero();
    int s;
    apply_reset("zero");
    run_frames("zero", 10, 0, 0, 0, -1, s);
    check_strobes("zero", s, 7);
  endtask

  task automatic test_ones();
    int s;
    apply_reset("ones");
    run_frames("ones", 8, 1, 0, 16'hFFFF, -1, s);
    check_strobes("ones", s, 5);
  endtask

  task automatic test_alternating();
    int s;
    apply_reset("alt");
    run_frames("alt", 8, 2, 0, 16'h8000, -1, s);
    check_strobes("alt", s, 5);
  endtask

  task automatic test_random_density();
    int s;
    apply_reset("dens4000");
    run_frames("dens4000", 8, 3, 16'h4000, -1, -1, s);
    check_strobes("dens4000", s, 5);
    apply_reset("densC000");
    run_frames("densC000", 8, 3, 16'hC000, -1, -1, s);
    check_strobes("densC000", s, 5);
    apply_reset("densrnd");
    run_frames("densrnd", 6, 3, $urandom_range(0, 65535), -1, -1, s);
    check_strobes("densrnd", s, 3);
  endtask

  task automatic test_midframe_reset();
    int s;
    apply_reset("midframe");
    // Stop with the counter at 30 in the fifth frame, after a clipped strobe.
    run_frames("midframe", 5, 1, 0, 16'hFFFF, 4 * R + 30, s);
    check_strobes("midframe", s, 1);
    apply_reset("midframe");
    run_frames("after_reset", 5, 1, 0, 16'hFFFF, -1, s);
    check_strobes("after_reset", s, 2);
  endtask

  initial begin
    build_kernel();
    @(negedge clk);
    test_reset();
    test_zero();
    test_ones();
    test_alternating();
    test_random_density();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
